// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and depth arithmetic.
// Functions operate on PTR_MAX_W-bit values; narrower pointers are zero-extended.
package fifo_pkg;

  localparam int MAX_ADDR_WIDTH = 12;
  localparam int PTR_MAX_W      = MAX_ADDR_WIDTH + 1;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero-extended high bits leave the prefix XOR unaffected.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
    logic [PTR_MAX_W-1:0] bin;
    bin = '0;
    for (int i = 0; i < PTR_MAX_W; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/wr_ptr_full_ctrl_gray2bin.sv
// Combinational Gray-to-binary decoder; shared by write- and read-side controllers.
module gray2bin_conv #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Bit i of the binary value is the XOR of all Gray bits at or above i.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/wr_ptr_full_ctrl.sv
// Write-domain pointer/status controller for an async FIFO of depth 2^ADDR_WIDTH.
// All status outputs are registered from the next-state pointer, so FULL has zero latency.
module wr_ptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = 3,
  parameter int AFULL_LEVEL = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_INC,
  input  logic                  CLR_OVF,
  input  logic [ADDR_WIDTH:0]   R_PTR_SYNC,
  output logic                  MEM_W_EN,
  output logic [ADDR_WIDTH-1:0] W_ADDR,
  output logic [ADDR_WIDTH:0]   W_PTR,
  output logic                  FULL,
  output logic                  ALMOST_FULL,
  output logic [ADDR_WIDTH:0]   W_LEVEL,
  output logic                  OVERFLOW
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [PW-1:0] bin_q, bin_d;
  logic [PW-1:0] gray_q, gray_d;
  logic [PW-1:0] level_q, level_d;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_match;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          ovf_q, ovf_d;

  gray2bin_conv #(.WIDTH(PW)) u_rptr_dec (
    .gray_i (R_PTR_SYNC),
    .bin_o  (rbin)
  );

  assign MEM_W_EN   = W_INC & ~full_q;
  // Full when write pointer is one lap ahead: top two Gray bits inverted, rest equal.
  assign full_match = {~R_PTR_SYNC[ADDR_WIDTH:ADDR_WIDTH-1], R_PTR_SYNC[ADDR_WIDTH-2:0]};

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    bin_d   = bin_q + {{ADDR_WIDTH{1'b0}}, MEM_W_EN};
    gray_d  = PW'(bin2gray(PTR_MAX_W'(bin_d)));
    full_d  = (gray_d == full_match);
    level_d = bin_d - rbin;
    afull_d = (level_d >= PW'(AFULL_LEVEL));
    ovf_d   = ovf_q;
    if (W_INC && full_q) begin
      ovf_d = 1'b1;
    end else if (CLR_OVF) begin
      ovf_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bin_q   <= '0;
      gray_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign W_ADDR      = bin_q[ADDR_WIDTH-1:0];
  assign W_PTR       = gray_q;
  assign FULL        = full_q;
  assign ALMOST_FULL = afull_q;
  assign W_LEVEL     = level_q;
  assign OVERFLOW    = ovf_q;

endmodule

// File: tb/tb_wr_ptr_full_ctrl.sv
// Directed bench for wr_ptr_full_ctrl: AW=3 main instance plus AW=2/4/6 sweep instances.
module tb_wr_ptr_full_ctrl;

  localparam int AW = 3;

  logic          clk;
  logic          rst;
  logic          w_inc;
  logic          clr_ovf;
  logic [AW:0]   r_ptr_sync;
  logic          mem_w_en;
  logic [AW-1:0] w_addr;
  logic [AW:0]   w_ptr;
  logic          full;
  logic          almost_full;
  logic [AW:0]   w_level;
  logic          overflow;

  logic [2:0]    sw_winc;
  logic [2:0]    sw_full;
  logic [2:0]    sw_afull;
  logic [2:0]    sw_lvl_depth;

  int tests_run;
  int tests_failed;

  wr_ptr_full_ctrl #(.ADDR_WIDTH(AW), .AFULL_LEVEL(6)) u_dut (
    .CLK         (clk),
    .RST         (rst),
    .W_INC       (w_inc),
    .CLR_OVF     (clr_ovf),
    .R_PTR_SYNC  (r_ptr_sync),
    .MEM_W_EN    (mem_w_en),
    .W_ADDR      (w_addr),
    .W_PTR       (w_ptr),
    .FULL        (full),
    .ALMOST_FULL (almost_full),
    .W_LEVEL     (w_level),
    .OVERFLOW    (overflow)
  );

  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int AWG = (g == 0) ? 2 : ((g == 1) ? 4 : 6);
    logic [AWG:0]   rp, wp, lvl;
    logic [AWG-1:0] wa;
    logic           mwe, ovf, fl, af;
    assign rp = '0;
    wr_ptr_full_ctrl #(.ADDR_WIDTH(AWG), .AFULL_LEVEL(1 << AWG)) u_sw (
      .CLK         (clk),
      .RST         (rst),
      .W_INC       (sw_winc[g]),
      .CLR_OVF     (1'b0),
      .R_PTR_SYNC  (rp),
      .MEM_W_EN    (mwe),
      .W_ADDR      (wa),
      .W_PTR       (wp),
      .FULL        (fl),
      .ALMOST_FULL (af),
      .W_LEVEL     (lvl),
      .OVERFLOW    (ovf)
    );
    assign sw_full[g]      = fl;
    assign sw_afull[g]     = af;
    assign sw_lvl_depth[g] = (int'(lvl) == (1 << AWG));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW:0] gray_of(input int b);
    logic [AW:0] v;
    v = AW'(0) + (AW+1)'(b);
    return v ^ (v >> 1);
  endfunction

  // Hand-computed Gray codes of 0..8.
  logic [3:0] exp_gray [9];
  logic [AW:0] prev_ptr;
  int          rlag;
  int          depth;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_gray     = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                     4'b0111, 4'b0101, 4'b0100, 4'b1100};
    rst        = 1'b1;
    w_inc      = 1'b0;
    clr_ovf    = 1'b0;
    r_ptr_sync = '0;
    sw_winc    = '0;
    #12;
    rst = 1'b0;
    tick();

    // 1. Asynchronous reset mid-cycle after some writes.
    w_inc = 1'b1;
    tick();
    tick();
    check("pre_rst_level", 32'(w_level), 32'd2);
    #3;
    rst = 1'b1;
    #1;
    check("rst_wptr", 32'(w_ptr), 32'd0);
    check("rst_level", 32'(w_level), 32'd0);
    check("rst_addr", 32'(w_addr), 32'd0);
    check("rst_flags", {29'd0, full, almost_full, overflow}, 32'd0);
    check("rst_mwe_follows", 32'(mem_w_en), 32'd1);
    w_inc = 1'b0;
    #2;
    check("rst_mwe_low", 32'(mem_w_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // 2. Fill with read pointer parked at zero.
    for (int n = 1; n <= 8; n++) begin
      w_inc = 1'b1;
      #1;
      check($sformatf("fill_addr%0d", n), 32'(w_addr), 32'(n - 1));
      check($sformatf("fill_mwe%0d", n), 32'(mem_w_en), 32'd1);
      tick();
      check($sformatf("fill_gray%0d", n), 32'(w_ptr), 32'(exp_gray[n]));
      check($sformatf("fill_full%0d", n), 32'(full), 32'(n == 8));
      check($sformatf("fill_afull%0d", n), 32'(almost_full), 32'(n >= 6));
      check($sformatf("fill_level%0d", n), 32'(w_level), 32'(n));
    end

    // 3. Overflow set, clear, and set-wins-over-clear.
    check("ovf_mwe_blocked", 32'(mem_w_en), 32'd0);
    tick();
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_ptr_hold", 32'(w_ptr), 32'b1100);
    check("ovf_addr_hold", 32'(w_addr), 32'd0);
    check("ovf_level_hold", 32'(w_level), 32'd8);
    w_inc   = 1'b0;
    clr_ovf = 1'b1;
    tick();
    check("ovf_clear", 32'(overflow), 32'd0);
    w_inc = 1'b1;
    tick();
    check("ovf_set_wins", 32'(overflow), 32'd1);
    w_inc   = 1'b0;
    clr_ovf = 1'b0;
    tick();
    check("ovf_hold", 32'(overflow), 32'd1);
    check("ovf_full_still", 32'(full), 32'd1);

    // 4. Read pointer advances by one while full.
    r_ptr_sync = 4'b0001;
    tick();
    check("drain_full", 32'(full), 32'd0);
    check("drain_level", 32'(w_level), 32'd7);
    check("drain_afull", 32'(almost_full), 32'd1);

    // 5. Stream 40 writes with the read pointer two writes behind.
    rst = 1'b1;
    #1;
    r_ptr_sync = '0;
    w_inc      = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("wrap_ovf_cleared", 32'(overflow), 32'd0);
    prev_ptr = w_ptr;
    for (int k = 0; k < 40; k++) begin
      rlag       = (k >= 2) ? k - 2 : 0;
      r_ptr_sync = gray_of(rlag % 16);
      w_inc      = 1'b1;
      tick();
      check($sformatf("wrap_ptr%0d", k), 32'(w_ptr), 32'(gray_of((k + 1) % 16)));
      check($sformatf("wrap_step%0d", k), 32'($countones(w_ptr ^ prev_ptr)), 32'd1);
      check($sformatf("wrap_level%0d", k), 32'(w_level), 32'((k + 1) - rlag));
      check($sformatf("wrap_addr%0d", k), 32'(w_addr), 32'((k + 1) % 8));
      check($sformatf("wrap_full%0d", k), {30'd0, full, almost_full}, 32'd0);
      prev_ptr = w_ptr;
    end
    w_inc = 1'b0;

    // 6. Parameter sweep: FULL and ALMOST_FULL rise together at DEPTH writes.
    for (int s = 0; s < 3; s++) begin
      depth = (s == 0) ? 4 : ((s == 1) ? 16 : 64);
      for (int n = 1; n <= depth; n++) begin
        sw_winc[s] = 1'b1;
        tick();
        if (n >= depth - 1) begin
          check($sformatf("sweep%0d_full_n%0d", s, n), 32'(sw_full[s]), 32'(n == depth));
          check($sformatf("sweep%0d_afull_n%0d", s, n), 32'(sw_afull[s]), 32'(n == depth));
          check($sformatf("sweep%0d_lvl_n%0d", s, n), 32'(sw_lvl_depth[s]), 32'(n == depth));
        end else if (sw_full[s] || sw_afull[s]) begin
          check($sformatf("sweep%0d_early_n%0d", s, n), {30'd0, sw_full[s], sw_afull[s]}, 32'd0);
        end
      end
      sw_winc[s] = 1'b0;
      tick();
      check($sformatf("sweep%0d_full_hold", s), 32'(sw_full[s]), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
